// File: rtl/disp_pkg.sv
// Shared definitions for the 4-digit multiplexed display scanner.
// Contents: digit count, segment constants, frame payload type, scan FSM state.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned FRAME_W    = NUM_DIGITS * SEG_W;
  localparam int unsigned IDX_W      = 2;

  localparam logic [SEG_W-1:0] SEG_ZERO  = 8'h3F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  // One byte per digit; element 0 is the least significant digit.
  typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] frame_t;

  typedef enum logic {
    DRIVE = 1'b0,
    BLANK = 1'b1
  } scan_state_e;

endpackage

// File: rtl/slot_timer.sv
// Slot counter for the scan FSM: counts 0..len-1 of the current phase and
// flags the terminal count; the counter clears itself on terminal count.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_blank          1 selects the blank-phase length, 0 the drive-phase length
//   o_cnt            current slot count (registered)
//   o_tc_c           terminal count of the current phase (combinational)
//   o_pre_tc_c       blank phase is one cycle before terminal count (combinational)
module slot_timer #(
  parameter int unsigned DRIVE_LEN = 1024,
  parameter int unsigned BLANK_LEN = 32,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_blank,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc_c,
  output logic             o_pre_tc_c
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;

  assign w_last = i_blank ? CNT_W'(BLANK_LEN - 1) : CNT_W'(DRIVE_LEN - 1);
  assign o_tc_c = (r_cnt == w_last);

  // Lets the parent register a pulse that lands exactly on the last blank cycle.
  assign o_pre_tc_c = i_blank && (BLANK_LEN >= 2) && (r_cnt == CNT_W'(BLANK_LEN - 2));

  assign o_cnt = r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (o_tc_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller with PWM brightness,
// anti-ghosting blank gap and a single-entry pending frame buffer.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// when a pending frame is transferred to the active frame.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-low reset
//   i_frame_valid     a new frame is offered on i_frame
//   i_frame           four segment bytes, [7:0] = digit 0
//   i_brightness      on-time in sixteenths of a drive slot
//   o_frame_ready     pending buffer empty
//   o_digitSelect     one-hot digit enable
//   o_segment         segment pattern of the enabled digit
//   o_frame_done      one-cycle pulse on the frame boundary cycle
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned SLOT_STEP    = 64,
  parameter int unsigned BLANK_CYCLES = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_valid,
  input  logic [FRAME_W-1:0]    i_frame,
  input  logic [3:0]            i_brightness,
  output logic                  o_frame_ready,
  output logic [NUM_DIGITS-1:0] o_digitSelect,
  output logic [SEG_W-1:0]      o_segment,
  output logic                  o_frame_done
);

  localparam int unsigned DRIVE_LEN = 16 * SLOT_STEP;
  localparam int unsigned MAX_LEN   = (DRIVE_LEN > BLANK_CYCLES) ? DRIVE_LEN : BLANK_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_LEN);

  scan_state_e           r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [3:0]            r_bright;
  frame_t                r_active;
  frame_t                r_pending;
  logic                  r_frame_ready;
  logic [NUM_DIGITS-1:0] r_dsel;
  logic [SEG_W-1:0]      r_seg;
  logic                  r_frame_done;

  logic [CNT_W-1:0]      w_cnt;
  logic                  w_tc;
  logic                  w_pre_tc;
  logic                  w_last_digit;
  logic                  w_boundary;
  logic                  w_done_next;
  logic [3:0]            w_bright_eff;
  logic [CNT_W-1:0]      w_on_lim;
  logic                  w_lit;
  frame_t                w_xfer;

  slot_timer #(
    .DRIVE_LEN (DRIVE_LEN),
    .BLANK_LEN (BLANK_CYCLES),
    .CNT_W     (CNT_W)
  ) u_slot_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst),
    .i_blank    (r_state == BLANK),
    .o_cnt      (w_cnt),
    .o_tc_c     (w_tc),
    .o_pre_tc_c (w_pre_tc)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit blanking zeros until a non-zero digit; digit 0 always kept.
  function automatic frame_t f_blank_leading_zeros(input frame_t f);
    frame_t r;
    logic   lead;
    r    = f;
    lead = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      if (lead && (r[IDX_W'(d)] == SEG_ZERO)) begin
        r[IDX_W'(d)] = SEG_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  assign w_xfer = f_blank_leading_zeros(r_pending);
`else
  assign w_xfer = r_pending;
`endif

  assign w_last_digit = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_boundary   = (r_state == BLANK) && w_tc && w_last_digit;

  // Look one cycle ahead so the registered pulse coincides with the boundary cycle.
  assign w_done_next = w_last_digit &&
                       (((r_state == BLANK) && w_pre_tc) ||
                        ((BLANK_CYCLES == 1) && (r_state == DRIVE) && w_tc));

  // On the first drive cycle the brightness register is still loading, so use the input.
  assign w_bright_eff = (w_cnt == '0) ? i_brightness : r_bright;
  assign w_on_lim     = CNT_W'(w_bright_eff) * CNT_W'(SLOT_STEP);
  assign w_lit        = (r_state == DRIVE) && (w_cnt < w_on_lim);

  // Scan FSM, frame buffers and registered display outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= DRIVE;
      r_idx         <= '0;
      r_bright      <= '0;
      r_active      <= '0;
      r_pending     <= '0;
      r_frame_ready <= 1'b1;
      r_dsel        <= '0;
      r_seg         <= SEG_BLANK;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= w_done_next;
      r_dsel       <= w_lit ? (NUM_DIGITS'(1) << r_idx) : '0;
      r_seg        <= w_lit ? r_active[r_idx] : SEG_BLANK;

      if ((r_state == DRIVE) && (w_cnt == '0)) begin
        r_bright <= i_brightness;
      end

      case (r_state)
        DRIVE: begin
          if (w_tc) begin
            r_state <= BLANK;
          end
        end
        BLANK: begin
          if (w_tc) begin
            r_state <= DRIVE;
            r_idx   <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= DRIVE;
      endcase

      // Boundary only consumes a frame that was already pending; a same-cycle offer
      // can only be accepted when the buffer was empty, so it waits one more frame.
      if (w_boundary && !r_frame_ready) begin
        r_active      <= w_xfer;
        r_frame_ready <= 1'b1;
      end else if (i_frame_valid && r_frame_ready) begin
        r_pending     <= i_frame;
        r_frame_ready <= 1'b0;
      end
    end
  end

  assign o_frame_ready = r_frame_ready;
  assign o_digitSelect = r_dsel;
  assign o_segment     = r_seg;
  assign o_frame_done  = r_frame_done;

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter SLOT_STEP, default 64: clock cycles per brightness step; the drive slot is 16*SLOT_STEP cycles.
REQ-002 SHALL have parameter BLANK_CYCLES, default 32: all-digits-off cycles after each drive slot (anti-ghosting).
REQ-003 SHALL have port i_clk, input, 1: the single clock.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port i_frame_valid, input, 1: a new frame is offered on i_frame.
REQ-006 SHALL have port i_frame, input, 32: segment patterns; [7:0] is digit 0 (least significant) and [31:24] is digit 3; active-high; bit 7 is dp.
REQ-007 SHALL have port i_brightness, input, 4: on-time in sixteenths of a slot; 0 is off.
REQ-008 SHALL have port o_frame_ready, output, 1: the pending buffer is empty.
REQ-009 SHALL have port o_digitSelect, output, 4: one-hot digit enable, active-high.
REQ-010 SHALL have port o_segment, output, 8: active-high segment pattern of the enabled digit.
REQ-011 SHALL have port o_frame_done, output, 1: one-cycle pulse at each frame boundary.

Function
REQ-012 SHALL accept a frame into the pending buffer on any cycle with i_frame_valid=1 and o_frame_ready=1; o_frame_ready SHALL go low the next cycle.
REQ-013 SHALL use a two-state FSM, DRIVE and BLANK, with slot counter slot_cnt and digit index idx (0..3).
REQ-014 In DRIVE, slot_cnt SHALL count 0..16*SLOT_STEP-1; on the terminal count, the FSM SHALL go to BLANK and clear slot_cnt.
REQ-015 In BLANK, slot_cnt SHALL count 0..BLANK_CYCLES-1; on the terminal count, the FSM SHALL go to DRIVE and advance idx modulo 4, wrapping 3 to 0.
REQ-016 SHALL sample i_brightness into a register on the first cycle of each DRIVE slot (slot_cnt=0).
REQ-017 In DRIVE, o_digitSelect SHALL equal (1<<idx) while slot_cnt < brightness_reg*SLOT_STEP, and 0 otherwise.
REQ-018 o_segment SHALL equal the active-frame byte for idx whenever o_digitSelect is non-zero, and 0 otherwise.
REQ-019 o_digitSelect and o_segment SHALL be registered, one cycle after the FSM state that produces them.
REQ-020 In BLANK, o_digitSelect and o_segment SHALL be 0.
REQ-021 The frame boundary SHALL be the last BLANK cycle of idx=3.
- o_frame_done pulses on that cycle.
- If the pending buffer is full, it moves to the active frame, and o_frame_ready returns to 1 the next cycle.
REQ-022 If acceptance and a boundary fall in the same cycle, the boundary SHALL use the prior pending state; the new frame stays pending until the next boundary.
REQ-023 A change of i_brightness mid-slot SHALL have no effect until the next slot.

Reset
REQ-024 While i_rst=0, the block SHALL hold:
- FSM in DRIVE, slot_cnt=0, idx=0, brightness_reg=0;
- active frame = 0, pending buffer empty;
- o_frame_ready=1, o_digitSelect=0, o_segment=0, o_frame_done=0.
REQ-025 Reset asserted mid-slot SHALL force all outputs to their reset values immediately (asynchronously), and scanning SHALL restart at digit 0 after release.

Configuration
REQ-026 With macro LEADING_ZERO_BLANK_EN defined, leading zero digits SHALL be blanked at frame transfer.
- Scanning from digit 3 downward, each digit equal to SEG_ZERO is replaced with 0 until the first non-SEG_ZERO digit.
- Digit 0 is never blanked.
REQ-027 Without LEADING_ZERO_BLANK_EN, the frame SHALL be transferred unmodified, with no extra logic.

Structure
REQ-028 Package disp_pkg SHALL hold:
- NUM_DIGITS=4;
- SEG_ZERO=8'h3F;
- SEG_BLANK=8'h00;
- the FSM state typedef {DRIVE, BLANK}.
REQ-029 Sub-module slot_timer SHALL hold slot_cnt and terminal-count detection; FSM, buffers and output registers stay in display_scan_ctrl.

Verification (SLOT_STEP=2, BLANK_CYCLES=3; drive slot 32 cycles, digit period 35, frame 140)
REQ-030 Reset: assert i_rst=0 mid-DRIVE -> outputs 0 and o_frame_ready=1 immediately; after release, the first enabled digit is 4'b0001.
REQ-031 Load frame 32'h4F5B063F with brightness 15 -> after the boundary:
- digit 0 shows 8'h3F for 30 cycles, then 2 cycles dark plus 3 blank cycles;
- digits 1, 2, 3 show 06, 5B, 4F in turn;
- o_frame_done pulses every 140 cycles.
REQ-032 Brightness 0 -> o_digitSelect stays 0 for a full frame and o_frame_done still pulses every 140 cycles; brightness 8 -> 16 on-cycles per slot.
REQ-033 Offer frame A, then frame B while o_frame_ready=0:
- B is not accepted;
- A becomes active at the boundary;
- B is accepted the cycle after o_frame_ready rises.
Also drive valid on the boundary cycle -> that frame shows one frame later.
REQ-034 Load 32'h3F3F063F:
- with LEADING_ZERO_BLANK_EN, digits 3 and 2 are dark, digit 1 shows 06, digit 0 shows 3F;
- without the macro, all four digits light.
Load 32'h3F3F3F3F with the macro -> only digit 0 lights.
